// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte producers
//
// Ports:
//   clk          system clock
//   nrst         asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i in bits [8i+7:8i]
//   req_last     per-requester end-of-message marker, releases the grant after that byte
//   req_ready    per-requester accept, a byte transfers on valid & ready
//   tx_data      byte presented to the transmitter
//   tx_latch     one-cycle latch pulse to the transmitter
//   tx_busy      transmitter busy flag
//   grant_id     current / last granted requester
//   active       a grant is held
//   timeout_err  sticky flag, tx_busy never rose after a latch

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 8,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_latch,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_LATCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [GW-1:0] r_grant;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_burst_cnt;
    logic [7:0]    r_timer;
    logic          r_last_flag;
    logic          r_timeout_err;

    logic          w_sel_valid;
    logic          w_sel_last;
    logic [7:0]    w_sel_data;
    logic          w_arb_hit;
    logic [GW-1:0] w_arb_id;
    int            w_dist;
    int            w_best;
    logic          w_xfer;
    logic [7:0]    w_cnt_next;
    logic          w_cap_hit;
    logic          w_busy_expire;

    // Mux out the granted requester's handshake signals.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Rotating priority: distance 0 is the requester just after the last
    // grant, the last grant itself has the lowest priority.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_id  = r_grant;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_grant)) % NUM_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_arb_id  = GW'(i);
                w_arb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == S_SEND) && (r_grant == GW'(i))) begin
                req_ready[i] = req_valid[i] & ~tx_busy;
            end
        end
    end

    assign w_xfer        = (r_state == S_SEND) && w_sel_valid && !tx_busy;
    // The count never passes MAX_BURST (<= 255) so 8 bits cannot wrap.
    assign w_cnt_next    = r_burst_cnt + 8'd1;
    assign w_cap_hit     = (w_cnt_next == 8'(MAX_BURST));
    assign w_busy_expire = ((r_timer + 8'd1) == 8'(BUSY_TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                w_state_nxt = w_arb_hit ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                if (!w_sel_valid)  w_state_nxt = S_ARB;
                else if (!tx_busy) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // On expiry the byte is presumed lost; move on without retry.
                if (tx_busy || w_busy_expire) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) w_state_nxt = r_last_flag ? S_ARB : S_SEND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_grant       <= GW'(NUM_REQ - 1);
            r_tx_data     <= 8'h00;
            r_burst_cnt   <= 8'h00;
            r_timer       <= 8'h00;
            r_last_flag   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == S_ARB) && w_arb_hit) begin
                r_grant     <= w_arb_id;
                r_burst_cnt <= 8'h00;
            end
            if (w_xfer) begin
                r_tx_data   <= w_sel_data;
                r_burst_cnt <= w_cnt_next;
                r_last_flag <= w_sel_last | w_cap_hit;
            end
            if (r_state == S_LATCH) begin
                r_timer <= 8'h00;
            end else if ((r_state == S_WAIT_BUSY) && !tx_busy && !w_busy_expire) begin
                r_timer <= r_timer + 8'd1;
            end
            if ((r_state == S_WAIT_BUSY) && !tx_busy && w_busy_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign tx_latch    = (r_state == S_LATCH);
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant;
    assign active      = (r_state != S_IDLE) && (r_state != S_ARB);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int BT = 8;

    logic           clk = 1'b0;
    logic           nrst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_latch;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_latch(tx_latch), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] pq[N][$];   // per-requester pending bytes, bit 8 = last
    int exp_q[$];
    int obs_q[$];           // grant*256 + data for every latch seen
    int m_ptr;
    int frame;
    bit stuck;
    int busy_cnt;
    int viol, ready_cyc, latch_cyc, ready_cnt, to_cyc;
    bit done;

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                h = pq[i][0];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]       = h[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; stuck = 1'b0; busy_cnt = 0; frame = 4;
        for (int i = 0; i < N; i++) pq[i].delete();
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Reference: rotate from the last grant to the next requester with data,
    // send until its last byte, the burst cap, or its data runs out.
    task automatic build_expected();
        logic [8:0] mq[N][$];
        logic [8:0] e;
        int g, cnt, idx;
        bit any;
        exp_q.delete();
        for (int i = 0; i < N; i++) mq[i] = pq[i];
        while (1) begin
            any = 1'b0;
            g = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (!any && mq[idx].size() > 0) begin
                    g = idx;
                    any = 1'b1;
                end
            end
            if (!any) break;
            cnt = 0;
            while (mq[g].size() > 0) begin
                e = mq[g].pop_front();
                exp_q.push_back(g * 256 + int'(e[7:0]));
                cnt++;
                if (e[8] || cnt == MB) break;
            end
            m_ptr = g;
        end
    endtask

    task automatic run_traffic(input int max_cyc);
        logic [N-1:0] hs;
        logic lat;
        obs_q.delete();
        viol = 0; ready_cyc = -1; latch_cyc = -1; ready_cnt = 0; to_cyc = -1; done = 1'b0;
        drive_inputs();
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (timeout_err && to_cyc < 0) to_cyc = cyc;
            if (req_ready != '0) begin
                ready_cnt++;
                if (ready_cyc < 0) ready_cyc = cyc;
            end
            lat = tx_latch;
            if (lat) begin
                obs_q.push_back(int'(grant_id) * 256 + int'(tx_data));
                if (latch_cyc < 0) latch_cyc = cyc;
                if (tx_busy) viol++;
            end
            hs = req_valid & req_ready;
            if (all_empty() && !active && !tx_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (hs[i]) void'(pq[i].pop_front());
            if (lat && !stuck) begin
                tx_busy = 1'b1;
                busy_cnt = frame;
            end else if (tx_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            drive_inputs();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        req_valid = '1; req_data = '1; req_last = '1; tx_busy = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", tx_latch); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", tx_data); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant: got %0d want 3", grant_id); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", active); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        pq[2].push_back({1'b1, 8'h41});
        m_ptr = N - 1;
        build_expected();
        run_traffic(200);
        checks++; if (!done) begin errors++; $display("FAIL single_done: got 0 want 1"); end
        checks++; if (ready_cyc !== 3) begin errors++; $display("FAIL single_ready_lat: got %0d want 3", ready_cyc); end
        checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL single_ready_len: got %0d want 1", ready_cnt); end
        checks++; if (latch_cyc !== 4) begin errors++; $display("FAIL single_latch_lat: got %0d want 4", latch_cyc); end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h241) begin
            errors++; $display("FAIL single_byte: got %0d latches first %h want 1 latch 241", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
        end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", active); end
    endtask

    task automatic test_round_robin();
        int ord[5] = '{0, 1, 2, 3, 0};
        do_reset();
        frame = 12;
        pq[0].push_back({1'b1, 8'h41}); pq[0].push_back({1'b1, 8'h45});
        pq[1].push_back({1'b1, 8'h42});
        pq[2].push_back({1'b1, 8'h43});
        pq[3].push_back({1'b1, 8'h44});
        m_ptr = N - 1;
        build_expected();
        run_traffic(2000);
        checks++; if (!done) begin errors++; $display("FAIL rr_done: got 0 want 1"); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rr_latch_busy: got %0d want 0", viol); end
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL rr_len: got %0d want 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++; if ((obs_q[i] / 256) !== ord[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, obs_q[i] / 256, ord[i]); end
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_burst_lock();
        int want[4] = '{32'h141, 32'h142, 32'h143, 32'h05a};
        do_reset();
        frame = 5;
        pq[0].push_back({1'b1, 8'h51});
        m_ptr = N - 1;
        build_expected();
        run_traffic(500);
        checks++; if (!done) begin errors++; $display("FAIL burst_pre_done: got 0 want 1"); end
        pq[1].push_back({1'b0, 8'h41}); pq[1].push_back({1'b0, 8'h42}); pq[1].push_back({1'b1, 8'h43});
        pq[0].push_back({1'b1, 8'h5a});
        build_expected();
        run_traffic(1000);
        checks++; if (!done) begin errors++; $display("FAIL burst_done: got 0 want 1"); end
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL burst_len: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== want[i]) begin errors++; $display("FAIL burst_seq[%0d]: got %h want %h", i, obs_q[i], want[i]); end
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_max_burst();
        int ord[7] = '{3, 3, 3, 3, 0, 3, 3};
        do_reset();
        frame = 3;
        pq[2].push_back({1'b1, 8'h20});
        m_ptr = N - 1;
        build_expected();
        run_traffic(500);
        checks++; if (!done) begin errors++; $display("FAIL cap_pre_done: got 0 want 1"); end
        for (int b = 0; b < 6; b++) pq[3].push_back({1'b0, 8'(8'h30 + b)});
        pq[0].push_back({1'b1, 8'h60});
        build_expected();
        run_traffic(2000);
        checks++; if (!done) begin errors++; $display("FAIL cap_done: got 0 want 1"); end
        checks++; if (obs_q.size() != 7) begin errors++; $display("FAIL cap_len: got %0d want 7", obs_q.size()); end
        for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
            checks++; if ((obs_q[i] / 256) !== ord[i]) begin errors++; $display("FAIL cap_order[%0d]: got %0d want %0d", i, obs_q[i] / 256, ord[i]); end
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL cap_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        stuck = 1'b1;
        pq[1].push_back({1'b0, 8'h71}); pq[1].push_back({1'b1, 8'h72});
        m_ptr = N - 1;
        build_expected();
        run_traffic(500);
        checks++; if (!done) begin errors++; $display("FAIL to_done: got 0 want 1"); end
        checks++; if ((to_cyc - latch_cyc) !== BT + 1) begin errors++; $display("FAIL to_delay: got %0d want %0d", to_cyc - latch_cyc, BT + 1); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL to_len: got %0d want 2", obs_q.size()); end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        do_reset();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        do_reset();
        req_valid = 4'b0010; req_data = 32'h0000_5500; req_last = 4'b0000;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_latch) begin got = 1'b1; break; end
            if (req_ready[1]) begin
                @(posedge clk); #1;
                req_valid = 4'b0000;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL mid_latch: got 0 want 1"); end
        @(negedge clk);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", active); end
        req_valid = 4'b0011;
        #2 nrst = 1'b0;
        #1;
        checks++; if (tx_latch !== 1'b0) begin errors++; $display("FAIL mid_rst_latch: got %b want 0", tx_latch); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_rst_active: got %b want 0", active); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mid_rst_grant: got %0d want 3", grant_id); end
        do_reset();
        frame = 6;
        pq[1].push_back({1'b1, 8'h11});
        pq[0].push_back({1'b1, 8'h10});
        m_ptr = N - 1;
        build_expected();
        run_traffic(500);
        checks++; if (!done) begin errors++; $display("FAIL mid_done: got 0 want 1"); end
        checks++;
        if (obs_q.size() < 1 || (obs_q[0] / 256) !== 0) begin
            errors++; $display("FAIL mid_first_grant: got %0d want 0", (obs_q.size() > 0) ? obs_q[0] / 256 : -1);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int nmsg, len;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            frame = $urandom_range(1, 10);
            for (int i = 0; i < N; i++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) pq[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            if (all_empty()) pq[$urandom_range(0, N - 1)].push_back({1'b1, 8'hA5});
            m_ptr = N - 1;
            build_expected();
            run_traffic(5000);
            checks++; if (!done) begin errors++; $display("FAIL rnd%0d_done: got 0 want 1", r); end
            checks++; if (viol !== 0) begin errors++; $display("FAIL rnd%0d_latch_busy: got %0d want 0", r, viol); end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_len: got %0d want %0d", r, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte[%0d]: got %h want %h", r, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_max_burst();
        test_timeout();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
